decodificador_barrido: RTL and testbench

Parametrised, registered successor to the team's 4-to-16 decoder. It decodes an ANCHO-bit index to NUM_SALIDAS one-hot (or one-cold) lines. It adds four modes: direct, single-cycle strobe, auto-scan with a prescaler, and hold. It drives display digit multiplexing, row scanning and chip-select generation in the lab designs.

---
 rtl/decodificador_barrido.sv | 111 +++++++++++
 tb/tb_decodificador_barrido.sv | 134 +++++++++++++
 2 files changed

// File: rtl/decodificador_barrido.sv
// decodificador_barrido: registered index decoder with direct, strobe, auto-scan and hold modes
module decodificador_barrido #(
    parameter int ANCHO       = 4,
    parameter int NUM_SALIDAS = 16,
    parameter int ACTIVO_BAJO = 0,
    parameter int DIV_BARRIDO = 4
) (
    input  logic                   Reloj,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic [1:0]             Modo,
    input  logic [ANCHO-1:0]       Entrada,
    input  logic                   Cargar,
    output logic [NUM_SALIDAS-1:0] Salida,
    output logic [ANCHO-1:0]       Indice,
    output logic                   Valido,
    output logic                   Error
);
    typedef enum logic [1:0] {DIRECTO = 2'b00, PULSO = 2'b01, BARRIDO = 2'b10, RETENCION = 2'b11} modo_e;

    localparam logic [NUM_SALIDAS-1:0] INACTIVO = {NUM_SALIDAS{ACTIVO_BAJO != 0}};
    localparam logic [ANCHO:0]         LIMITE   = (ANCHO+1)'(NUM_SALIDAS);
    localparam logic [ANCHO-1:0]       ULTIMO   = ANCHO'(NUM_SALIDAS - 1);
    localparam logic [15:0]            TERMINAL = 16'(DIV_BARRIDO - 1);

    if (NUM_SALIDAS < 2 || NUM_SALIDAS > 2**ANCHO) begin : g_num_invalido
        $error("NUM_SALIDAS must lie in 2..2**ANCHO");
    end
    if (DIV_BARRIDO < 1 || DIV_BARRIDO > 65535) begin : g_div_invalido
        $error("DIV_BARRIDO must lie in 1..65535");
    end

    function automatic logic [NUM_SALIDAS-1:0] patron(input logic [ANCHO-1:0] i);
        return INACTIVO ^ (NUM_SALIDAS'(1) << i);
    endfunction

    modo_e                   modo_i, modo_q;
    logic [15:0]             presc_q, presc_d;
    logic [ANCHO-1:0]        indice_q, indice_d, siguiente;
    logic [NUM_SALIDAS-1:0]  salida_q, salida_d;
    logic                    valido_q, valido_d, error_q, error_d;
    logic                    en_rango, cambio, terminal, carga_ok;

    assign modo_i = modo_e'(Modo);

    // Next-state selection per mode; a mode change always restarts the prescaler
    always_comb begin
        en_rango  = {1'b0, Entrada} < LIMITE;
        cambio    = modo_i != modo_q;
        terminal  = presc_q == TERMINAL;
        carga_ok  = Cargar && en_rango;
        siguiente = (indice_q == ULTIMO) ? '0 : indice_q + 1'b1;
        indice_d  = indice_q;
        presc_d   = cambio ? '0 : presc_q;
        valido_d  = 1'b0;
        error_d   = 1'b0;
        case (modo_i)
            DIRECTO: begin
                indice_d = en_rango ? Entrada : indice_q;
                valido_d = en_rango;
                error_d  = !en_rango;
            end
            PULSO: begin
                indice_d = carga_ok ? Entrada : indice_q;
                valido_d = carga_ok;
                error_d  = Cargar && !en_rango;
            end
            BARRIDO: begin
                if (carga_ok) begin
                    indice_d = Entrada;
                    presc_d  = '0;
                end else if (!cambio) begin
                    indice_d = terminal ? siguiente : indice_q;
                    presc_d  = terminal ? '0 : presc_q + 16'd1;
                end
                valido_d = 1'b1;
                error_d  = Cargar && !en_rango;
            end
            default: valido_d = valido_q;
        endcase
        salida_d = (modo_i == RETENCION) ? salida_q : (valido_d ? patron(indice_d) : INACTIVO);
    end

    // State and output registers; Enable low blanks outputs but freezes index, prescaler and mode
    always_ff @(posedge Reloj) begin
        if (Reset) begin
            modo_q   <= DIRECTO;
            presc_q  <= '0;
            indice_q <= '0;
            salida_q <= INACTIVO;
            valido_q <= 1'b0;
            error_q  <= 1'b0;
        end else if (!Enable) begin
            salida_q <= INACTIVO;
            valido_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            modo_q   <= modo_i;
            presc_q  <= presc_d;
            indice_q <= indice_d;
            salida_q <= salida_d;
            valido_q <= valido_d;
            error_q  <= error_d;
        end
    end

    assign Salida = salida_q;
    assign Indice = indice_q;
    assign Valido = valido_q;
    assign Error  = error_q;
endmodule

// File: tb/tb_decodificador_barrido.sv
// tb_decodificador_barrido: directed vector bench over three decoder configurations
module tb_decodificador_barrido;
    localparam logic [1:0] D = 2'd0, P = 2'd1, B = 2'd2, R = 2'd3;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  modo;
        logic [3:0]  ent;
        logic        car;
        int          sel;
        logic [15:0] sal;
        logic [3:0]  idx;
        logic        val;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b1, car = 1'b0;
    logic [1:0] modo = 2'd0;
    logic [3:0] ent = 4'd0;
    logic [15:0] sal0, sal2;
    logic [11:0] sal1;
    logic [3:0] idx0, idx1, idx2;
    logic val0, val1, val2, err0, err1, err2;
    int checks = 0, failures = 0;
    vec_t tabla[$];

    always #5 clk = ~clk;

    decodificador_barrido #(.ANCHO(4), .NUM_SALIDAS(16), .ACTIVO_BAJO(0), .DIV_BARRIDO(4)) dut0 (
        .Reloj(clk), .Reset(rst), .Enable(en), .Modo(modo), .Entrada(ent), .Cargar(car),
        .Salida(sal0), .Indice(idx0), .Valido(val0), .Error(err0));
    decodificador_barrido #(.ANCHO(4), .NUM_SALIDAS(12), .ACTIVO_BAJO(0), .DIV_BARRIDO(3)) dut1 (
        .Reloj(clk), .Reset(rst), .Enable(en), .Modo(modo), .Entrada(ent), .Cargar(car),
        .Salida(sal1), .Indice(idx1), .Valido(val1), .Error(err1));
    decodificador_barrido #(.ANCHO(4), .NUM_SALIDAS(16), .ACTIVO_BAJO(1), .DIV_BARRIDO(4)) dut2 (
        .Reloj(clk), .Reset(rst), .Enable(en), .Modo(modo), .Entrada(ent), .Cargar(car),
        .Salida(sal2), .Indice(idx2), .Valido(val2), .Error(err2));

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m, input logic [3:0] x,
                                input logic c, input int s, input logic [15:0] sa, input logic [3:0] ix,
                                input logic va, input logic er);
        vec_t v;
        v.rst = r; v.en = e; v.modo = m; v.ent = x; v.car = c; v.sel = s;
        v.sal = sa; v.idx = ix; v.val = va; v.err = er;
        return v;
    endfunction

    task automatic paso(input vec_t v);
        logic [15:0] s;
        logic [3:0] i;
        logic va, er;
        rst = v.rst; en = v.en; modo = v.modo; ent = v.ent; car = v.car;
        @(posedge clk);
        #1;
        if (v.sel == 0) begin
            s = sal0; i = idx0; va = val0; er = err0;
        end else if (v.sel == 1) begin
            s = {4'h0, sal1}; i = idx1; va = val1; er = err1;
        end else begin
            s = sal2; i = idx2; va = val2; er = err2;
        end
        checks++;
        if ({s, i, va, er} !== {v.sal, v.idx, v.val, v.err}) begin
            failures++;
            $display("FAIL step%0d dut%0d: got sal=%h idx=%0d val=%b err=%b, expected sal=%h idx=%0d val=%b err=%b",
                     checks, v.sel, s, i, va, er, v.sal, v.idx, v.val, v.err);
        end
    endtask

    initial begin
        int esp[8] = '{10, 10, 10, 11, 11, 11, 0, 0};
        tabla.push_back(mk(1, 1, D, 3, 0, 0, 16'h0000, 0, 0, 0));
        tabla.push_back(mk(1, 1, D, 3, 0, 0, 16'h0000, 0, 0, 0));
        for (int i = 0; i < 16; i++) tabla.push_back(mk(0, 1, D, 4'(i), 0, 0, 16'(1) << i, 4'(i), 1, 0));
        tabla.push_back(mk(0, 1, D, 6, 1, 0, 16'h0040, 6, 1, 0));
        tabla.push_back(mk(0, 0, D, 2, 0, 0, 16'h0000, 6, 0, 0));
        tabla.push_back(mk(0, 1, D, 2, 0, 0, 16'h0004, 2, 1, 0));
        tabla.push_back(mk(1, 1, D, 0, 0, 1, 16'h000, 0, 0, 0));
        tabla.push_back(mk(0, 1, D, 5, 0, 1, 16'h020, 5, 1, 0));
        tabla.push_back(mk(0, 1, D, 13, 0, 1, 16'h000, 5, 0, 1));
        tabla.push_back(mk(0, 1, D, 12, 1, 1, 16'h000, 5, 0, 1));
        tabla.push_back(mk(0, 1, D, 11, 0, 1, 16'h800, 11, 1, 0));
        tabla.push_back(mk(0, 1, P, 14, 1, 1, 16'h000, 11, 0, 1));
        tabla.push_back(mk(0, 1, P, 14, 0, 1, 16'h000, 11, 0, 0));
        tabla.push_back(mk(0, 1, P, 3, 1, 1, 16'h008, 3, 1, 0));
        tabla.push_back(mk(1, 1, D, 0, 0, 2, 16'hFFFF, 0, 0, 0));
        tabla.push_back(mk(0, 1, P, 5, 0, 2, 16'hFFFF, 0, 0, 0));
        tabla.push_back(mk(0, 1, P, 5, 1, 2, 16'hFFDF, 5, 1, 0));
        tabla.push_back(mk(0, 1, P, 5, 0, 2, 16'hFFFF, 5, 0, 0));
        tabla.push_back(mk(0, 1, P, 1, 1, 2, 16'hFFFD, 1, 1, 0));
        tabla.push_back(mk(0, 1, P, 2, 1, 2, 16'hFFFB, 2, 1, 0));
        tabla.push_back(mk(0, 1, P, 3, 1, 2, 16'hFFF7, 3, 1, 0));
        tabla.push_back(mk(0, 1, P, 3, 0, 2, 16'hFFFF, 3, 0, 0));
        tabla.push_back(mk(0, 1, P, 9, 1, 2, 16'hFDFF, 9, 1, 0));
        tabla.push_back(mk(0, 1, R, 0, 1, 2, 16'hFDFF, 9, 1, 0));
        tabla.push_back(mk(0, 1, R, 15, 0, 2, 16'hFDFF, 9, 1, 0));
        foreach (tabla[k]) paso(tabla[k]);

        paso(mk(1, 1, D, 0, 0, 1, 16'h000, 0, 0, 0));
        paso(mk(0, 1, D, 10, 0, 1, 16'h400, 10, 1, 0));
        for (int k = 0; k < 8; k++) paso(mk(0, 1, B, 0, 0, 1, 16'(1) << esp[k], 4'(esp[k]), 1, 0));
        paso(mk(0, 1, B, 4, 1, 1, 16'h010, 4, 1, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h010, 4, 1, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h010, 4, 1, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h020, 5, 1, 0));
        paso(mk(0, 1, B, 13, 1, 1, 16'h020, 5, 1, 1));
        paso(mk(0, 1, B, 0, 0, 1, 16'h020, 5, 1, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h040, 6, 1, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h040, 6, 1, 0));
        for (int k = 0; k < 5; k++) paso(mk(0, 0, B, 0, 0, 1, 16'h000, 6, 0, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h040, 6, 1, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h080, 7, 1, 0));
        paso(mk(1, 1, B, 0, 0, 1, 16'h000, 0, 0, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h001, 0, 1, 0));

        paso(mk(0, 1, D, 9, 0, 0, 16'h0200, 9, 1, 0));
        paso(mk(0, 1, R, 3, 1, 0, 16'h0200, 9, 1, 0));
        paso(mk(0, 1, R, 15, 0, 0, 16'h0200, 9, 1, 0));
        paso(mk(0, 1, R, 2, 1, 0, 16'h0200, 9, 1, 0));

        paso(mk(0, 1, B, 0, 0, 1, 16'h200, 9, 1, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h200, 9, 1, 0));
        paso(mk(0, 1, R, 0, 0, 1, 16'h200, 9, 1, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h200, 9, 1, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h200, 9, 1, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h200, 9, 1, 0));
        paso(mk(0, 1, B, 0, 0, 1, 16'h400, 10, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
